// File: rtl/riffa_axi_lite_pkg.sv
// Shared frame layout, response codes and FSM encoding for the RIFFA AXI-Lite
// register bridge (host-side initiator).
package riffa_axi_lite_pkg;

  localparam int ADDR_LSB     = 0;
  localparam int ADDR_MSB     = 31;
  localparam int DATA_LSB     = 32;
  localparam int DATA_MSB     = 63;
  localparam int TAG_LSB      = 64;
  localparam int TAG_MSB      = 95;
  localparam int STRB_LSB     = 96;
  localparam int STRB_MSB     = 99;
  localparam int REQ_TYPE_BIT = 100;
  localparam int RESP_LSB     = 101;
  localparam int RESP_MSB     = 102;

  localparam logic C_RD_REQ = 1'b0;
  localparam logic C_WR_REQ = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [31:0] C_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HDR,
    S_SEND_DATA,
    S_WAIT_RESP,
    S_AXI_RESP
  } state_t;

  typedef struct packed {
    logic [24:0] rsvd;
    logic [1:0]  resp;
    logic        req_type;
    logic [3:0]  strb;
    logic [31:0] tag;
    logic [31:0] data;
    logic [31:0] addr;
  } frame_t;

  function automatic frame_t pack_req(input logic        req_type,
                                      input logic [31:0] addr,
                                      input logic [31:0] data,
                                      input logic [3:0]  strb,
                                      input logic [31:0] tag);
    logic [127:0] v;
    v                        = '0;
    v[ADDR_MSB:ADDR_LSB]     = addr;
    v[DATA_MSB:DATA_LSB]     = data;
    v[TAG_MSB:TAG_LSB]       = tag;
    v[STRB_MSB:STRB_LSB]     = strb;
    v[REQ_TYPE_BIT]          = req_type;
    v[RESP_MSB:RESP_LSB]     = OKAY;
    return frame_t'(v);
  endfunction

endpackage

// File: rtl/riffa_axi_lite_initiator.sv
// AXI-Lite slave that turns each register access into one 128-bit RIFFA request
// frame and completes reads from tagged RIFFA response frames.
module riffa_axi_lite_initiator
  import riffa_axi_lite_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH        = 128,
  parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES        = 1024
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               s_axi_lite_awvalid,
  output logic                               s_axi_lite_awready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                               s_axi_lite_wvalid,
  output logic                               s_axi_lite_wready,
  input  logic [31:0]                        s_axi_lite_wdata,
  input  logic [3:0]                         s_axi_lite_wstrb,
  output logic                               s_axi_lite_bvalid,
  input  logic                               s_axi_lite_bready,
  output logic [1:0]                         s_axi_lite_bresp,
  input  logic                               s_axi_lite_arvalid,
  output logic                               s_axi_lite_arready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  output logic                               s_axi_lite_rvalid,
  input  logic                               s_axi_lite_rready,
  output logic [31:0]                        s_axi_lite_rdata,
  output logic [1:0]                         s_axi_lite_rresp,
  output logic                               CHNL_TX,
  input  logic                               CHNL_TX_ACK,
  output logic                               CHNL_TX_LAST,
  output logic [31:0]                        CHNL_TX_LEN,
  output logic [30:0]                        CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]        CHNL_TX_DATA,
  output logic                               CHNL_TX_DATA_VALID,
  input  logic                               CHNL_TX_DATA_REN,
  input  logic                               CHNL_RX,
  output logic                               CHNL_RX_ACK,
  input  logic [C_PCI_DATA_WIDTH-1:0]        CHNL_RX_DATA,
  input  logic                               CHNL_RX_DATA_VALID,
  output logic                               CHNL_RX_DATA_REN,
  output logic                               tag_error,
  output logic                               timeout_error
);

  localparam logic [31:0] LP_TO_LAST = 32'(C_TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  frame_t      r_frame;
  logic [31:0] r_tag;
  logic [31:0] r_cnt;
  logic        r_last_grant;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;
  logic        r_rx_ren;
  logic        r_tag_err;
  logic        r_to_err;

  logic        w_aw_both;
  logic        w_aw_grant;
  logic        w_ar_grant;
  logic        w_rx_fire;
  logic [31:0] w_rx_tag;
  logic        w_rx_hit;
  logic        w_expired;
  logic        w_unused;

  assign w_aw_both = s_axi_lite_awvalid && s_axi_lite_wvalid;
  assign w_rx_fire = CHNL_RX_DATA_VALID && r_rx_ren;
  assign w_rx_tag  = CHNL_RX_DATA[TAG_MSB:TAG_LSB];
  assign w_rx_hit  = (r_state == S_WAIT_RESP) && w_rx_fire && (w_rx_tag == r_frame.tag);
  assign w_expired = (r_state == S_WAIT_RESP) && (r_cnt == LP_TO_LAST);
  // Response frame fields that carry nothing for a read completion.
  assign w_unused  = ^{CHNL_RX_DATA[127:RESP_MSB+1], CHNL_RX_DATA[REQ_TYPE_BIT:STRB_LSB],
                       CHNL_RX_DATA[ADDR_MSB:ADDR_LSB]};

  assign CHNL_TX_LAST     = 1'b1;
  assign CHNL_TX_LEN      = 32'd4;
  assign CHNL_TX_OFF      = '0;
  assign CHNL_TX_DATA     = r_frame;
  assign CHNL_RX_ACK      = CHNL_RX;
  assign CHNL_RX_DATA_REN = r_rx_ren;
  assign s_axi_lite_bresp = r_bresp;
  assign s_axi_lite_rdata = r_rdata;
  assign s_axi_lite_rresp = r_rresp;
  assign tag_error        = r_tag_err;
  assign timeout_error    = r_to_err;

  always_comb begin
    w_state_nxt        = r_state;
    w_aw_grant         = 1'b0;
    w_ar_grant         = 1'b0;
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    s_axi_lite_bvalid  = 1'b0;
    s_axi_lite_rvalid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // On a tie the side not served last time wins; after reset that is the write.
        if (w_aw_both && (!s_axi_lite_arvalid || r_last_grant == C_RD_REQ)) begin
          w_aw_grant = 1'b1;
        end else if (s_axi_lite_arvalid) begin
          w_ar_grant = 1'b1;
        end
        if (w_aw_grant || w_ar_grant) begin
          w_state_nxt = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        CHNL_TX = 1'b1;
        if (CHNL_TX_ACK) begin
          w_state_nxt = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        CHNL_TX_DATA_VALID = 1'b1;
        if (CHNL_TX_DATA_REN) begin
          w_state_nxt = (r_frame.req_type == C_WR_REQ) ? S_AXI_RESP : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (w_rx_hit || w_expired) begin
          w_state_nxt = S_AXI_RESP;
        end
      end
      S_AXI_RESP: begin
        if (r_frame.req_type == C_WR_REQ) begin
          s_axi_lite_bvalid = 1'b1;
          if (s_axi_lite_bready) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          s_axi_lite_rvalid = 1'b1;
          if (s_axi_lite_rready) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign s_axi_lite_awready = w_aw_grant;
  assign s_axi_lite_wready  = w_aw_grant;
  assign s_axi_lite_arready = w_ar_grant;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame      <= '0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_last_grant <= C_RD_REQ;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_bresp      <= '0;
      r_rx_ren     <= 1'b0;
      r_tag_err    <= 1'b0;
      r_to_err     <= 1'b0;
    end else begin
      r_rx_ren  <= 1'b1;
      r_tag_err <= w_rx_fire && !w_rx_hit;
      r_to_err  <= w_expired && !w_rx_hit;

      if (w_aw_grant) begin
        r_frame      <= pack_req(C_WR_REQ, 32'(s_axi_lite_awaddr), s_axi_lite_wdata,
                                 s_axi_lite_wstrb, r_tag);
        r_last_grant <= C_WR_REQ;
      end else if (w_ar_grant) begin
        r_frame      <= pack_req(C_RD_REQ, 32'(s_axi_lite_araddr), '0, '0, r_tag);
        r_last_grant <= C_RD_REQ;
      end

      if (r_state == S_SEND_DATA && CHNL_TX_DATA_REN) begin
        r_tag <= r_tag + 32'd1;
        r_cnt <= '0;
        if (r_frame.req_type == C_WR_REQ) begin
          r_bresp <= OKAY;
        end
      end

      if (r_state == S_WAIT_RESP) begin
        r_cnt <= r_cnt + 32'd1;
        if (w_rx_hit) begin
          r_rdata <= CHNL_RX_DATA[DATA_MSB:DATA_LSB];
          r_rresp <= CHNL_RX_DATA[RESP_MSB:RESP_LSB];
        end else if (w_expired) begin
          r_rdata <= C_TIMEOUT_RDATA;
          r_rresp <= SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_riffa_axi_lite_initiator.sv
// Scoreboard bench for riffa_axi_lite_initiator: directed AXI-Lite traffic, a
// RIFFA TX sink and RX frame source, with a monitor popping expected results.
module tb_riffa_axi_lite_initiator;

  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          s_axi_lite_awvalid, s_axi_lite_awready;
  logic [31:0]   s_axi_lite_awaddr;
  logic          s_axi_lite_wvalid, s_axi_lite_wready;
  logic [31:0]   s_axi_lite_wdata;
  logic [3:0]    s_axi_lite_wstrb;
  logic          s_axi_lite_bvalid, s_axi_lite_bready;
  logic [1:0]    s_axi_lite_bresp;
  logic          s_axi_lite_arvalid, s_axi_lite_arready;
  logic [31:0]   s_axi_lite_araddr;
  logic          s_axi_lite_rvalid, s_axi_lite_rready;
  logic [31:0]   s_axi_lite_rdata;
  logic [1:0]    s_axi_lite_rresp;
  logic          CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST;
  logic [31:0]   CHNL_TX_LEN;
  logic [30:0]   CHNL_TX_OFF;
  logic [127:0]  CHNL_TX_DATA;
  logic          CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;
  logic          CHNL_RX, CHNL_RX_ACK;
  logic [127:0]  CHNL_RX_DATA;
  logic          CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;
  logic          tag_error, timeout_error;

  riffa_axi_lite_initiator #(
    .C_PCI_DATA_WIDTH(128),
    .C_S_AXI_LITE_ADDR_WIDTH(32),
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .s_axi_lite_awvalid(s_axi_lite_awvalid), .s_axi_lite_awready(s_axi_lite_awready),
    .s_axi_lite_awaddr(s_axi_lite_awaddr),
    .s_axi_lite_wvalid(s_axi_lite_wvalid), .s_axi_lite_wready(s_axi_lite_wready),
    .s_axi_lite_wdata(s_axi_lite_wdata), .s_axi_lite_wstrb(s_axi_lite_wstrb),
    .s_axi_lite_bvalid(s_axi_lite_bvalid), .s_axi_lite_bready(s_axi_lite_bready),
    .s_axi_lite_bresp(s_axi_lite_bresp),
    .s_axi_lite_arvalid(s_axi_lite_arvalid), .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_araddr(s_axi_lite_araddr),
    .s_axi_lite_rvalid(s_axi_lite_rvalid), .s_axi_lite_rready(s_axi_lite_rready),
    .s_axi_lite_rdata(s_axi_lite_rdata), .s_axi_lite_rresp(s_axi_lite_rresp),
    .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
    .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
    .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN),
    .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_DATA(CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
    .tag_error(tag_error), .timeout_error(timeout_error)
  );

  always #5 CLK = ~CLK;

  logic [127:0] q_tx[$];
  logic [1:0]   q_b[$];
  logic [33:0]  q_r[$];
  int n_checks = 0;
  int n_err = 0;
  int exp_tagerr = 0, seen_tagerr = 0;
  int exp_to = 0, seen_to = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic missing(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event seen/awaited without a matching expectation or within bound", name);
  endtask

  // RIFFA TX sink: acknowledge header and accept data in the cycle they appear.
  initial begin
    CHNL_TX_ACK = 1'b0;
    CHNL_TX_DATA_REN = 1'b0;
    forever begin
      @(negedge CLK);
      CHNL_TX_ACK = CHNL_TX;
      CHNL_TX_DATA_REN = CHNL_TX_DATA_VALID;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        if (CHNL_TX && CHNL_TX_ACK)
          chk("tx_hdr_consts", {CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF}, {1'b1, 32'd4, 31'd0});
        if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
          if (q_tx.size() == 0) missing("tx_frame_unexpected");
          else chk("tx_frame", CHNL_TX_DATA, q_tx.pop_front());
        end
        if (s_axi_lite_bvalid && s_axi_lite_bready) begin
          if (q_b.size() == 0) missing("b_unexpected");
          else chk("bresp", s_axi_lite_bresp, q_b.pop_front());
        end
        if (s_axi_lite_rvalid && s_axi_lite_rready) begin
          if (q_r.size() == 0) missing("r_unexpected");
          else chk("rresp_rdata", {s_axi_lite_rresp, s_axi_lite_rdata}, q_r.pop_front());
        end
        if (tag_error) seen_tagerr++;
        if (timeout_error) seen_to++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    s_axi_lite_awaddr = a; s_axi_lite_wdata = d; s_axi_lite_wstrb = s;
    s_axi_lite_awvalid = 1'b1; s_axi_lite_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (s_axi_lite_awready && s_axi_lite_wready) begin ok = 1'b1; break; end
    end
    if (!ok) missing("aw_w_handshake");
    @(posedge CLK); #1;
    s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    bit ok = 1'b0;
    s_axi_lite_araddr = a;
    s_axi_lite_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (s_axi_lite_arready) begin ok = 1'b1; break; end
    end
    if (!ok) missing("ar_handshake");
    @(posedge CLK); #1;
    s_axi_lite_arvalid = 1'b0;
    @(negedge CLK);
    chk("ar_to_chnl_tx_latency", CHNL_TX, 1'b1);
  endtask

  task automatic wait_tx_data();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (CHNL_TX_DATA_VALID) begin ok = 1'b1; break; end
    end
    if (!ok) missing("tx_data_wait");
  endtask

  task automatic send_rx(input logic [31:0] tag, input logic [31:0] data, input logic [1:0] resp);
    @(posedge CLK); #1;
    CHNL_RX = 1'b1;
    CHNL_RX_DATA = {25'd0, resp, 1'b0, 4'd0, tag, data, 32'd0};
    CHNL_RX_DATA_VALID = 1'b1;
    @(negedge CLK);
    chk("rx_ack", CHNL_RX_ACK, 1'b1);
    @(posedge CLK); #1;
    CHNL_RX = 1'b0;
    CHNL_RX_DATA_VALID = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_ctrl"}, {s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready,
        s_axi_lite_bvalid, s_axi_lite_rvalid, CHNL_TX, CHNL_TX_DATA_VALID,
        tag_error, timeout_error, CHNL_RX_DATA_REN}, 10'd0);
    chk({tagname, "_resp"}, {s_axi_lite_bresp, s_axi_lite_rresp, s_axi_lite_rdata}, 36'd0);
    chk({tagname, "_txdata"}, CHNL_TX_DATA, 128'd0);
  endtask

  initial begin
    int n;
    bit hit;
    RST = 1'b1;
    s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0; s_axi_lite_arvalid = 1'b0;
    s_axi_lite_awaddr = '0; s_axi_lite_wdata = '0; s_axi_lite_wstrb = '0; s_axi_lite_araddr = '0;
    s_axi_lite_bready = 1'b1; s_axi_lite_rready = 1'b1;
    CHNL_RX = 1'b0; CHNL_RX_DATA = '0; CHNL_RX_DATA_VALID = 1'b0;

    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    chk("reset_tx_consts", {CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF}, {1'b1, 32'd4, 31'd0});
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rx_ren_after_reset", CHNL_RX_DATA_REN, 1'b1);
    @(posedge CLK); #1;

    // Posted write, tag 0.
    q_tx.push_back(128'h0000001F_00000000_A5A50001_00000044);
    q_b.push_back(2'b00);
    axi_write(32'h44, 32'hA5A5_0001, 4'hF);
    repeat (8) @(posedge CLK); #1;

    // Read, tag 1.
    q_tx.push_back(128'h00000000_00000001_00000000_00000010);
    q_r.push_back({2'b00, 32'h1234_5678});
    axi_read(32'h10);
    wait_tx_data();
    send_rx(32'd1, 32'h1234_5678, 2'b00);
    repeat (4) @(posedge CLK); #1;

    // Read, tag 2: wrong tag first, then the right one.
    q_tx.push_back(128'h00000000_00000002_00000000_00000040);
    q_r.push_back({2'b01, 32'h5A5A_0F0F});
    exp_tagerr++;
    axi_read(32'h40);
    wait_tx_data();
    send_rx(32'd7, 32'hBBBB_BBBB, 2'b00);
    send_rx(32'd2, 32'h5A5A_0F0F, 2'b01);
    repeat (4) @(posedge CLK); #1;

    // Read, tag 3: no response, then a late frame.
    q_tx.push_back(128'h00000000_00000003_00000000_00000050);
    q_r.push_back({2'b10, 32'hDEAD_BEEF});
    exp_to++;
    axi_read(32'h50);
    wait_tx_data();
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK); #1;
      if (timeout_error) begin hit = 1'b1; break; end
      n++;
    end
    chk("timeout_wait_cycles", n, TO);
    chk("timeout_seen", hit, 1'b1);
    exp_tagerr++;
    send_rx(32'd3, 32'h9999_9999, 2'b00);
    repeat (4) @(posedge CLK); #1;

    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Tie after reset: write (tag 0) before read (tag 1).
    q_tx.push_back(128'h00000013_00000000_000000AB_00000020);
    q_tx.push_back(128'h00000000_00000001_00000000_00000030);
    q_b.push_back(2'b00);
    q_r.push_back({2'b00, 32'hCAFE_F00D});
    fork
      axi_write(32'h20, 32'h0000_00AB, 4'h3);
      begin
        axi_read(32'h30);
        wait_tx_data();
        send_rx(32'd1, 32'hCAFE_F00D, 2'b00);
      end
    join
    repeat (4) @(posedge CLK); #1;

    // A lone write (tag 2) leaves the write as last grant, so the next tie goes to the read.
    q_tx.push_back(128'h00000011_00000002_00000011_00000060);
    q_b.push_back(2'b00);
    axi_write(32'h60, 32'h0000_0011, 4'h1);
    repeat (6) @(posedge CLK); #1;
    q_tx.push_back(128'h00000000_00000003_00000000_00000074);
    q_tx.push_back(128'h0000001F_00000004_00000022_00000070);
    q_r.push_back({2'b00, 32'h7777_0074});
    q_b.push_back(2'b00);
    fork
      axi_write(32'h70, 32'h0000_0022, 4'hF);
      begin
        axi_read(32'h74);
        wait_tx_data();
        send_rx(32'd3, 32'h7777_0074, 2'b00);
      end
    join
    repeat (4) @(posedge CLK); #1;

    // Reset while waiting for a read response (tag 5); the read is abandoned.
    s_axi_lite_rready = 1'b0;
    q_tx.push_back(128'h00000000_00000005_00000000_00000080);
    axi_read(32'h80);
    wait_tx_data();
    repeat (3) @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    @(posedge CLK); #1;
    RST = 1'b0;
    s_axi_lite_rready = 1'b1;
    @(posedge CLK); #1;

    q_tx.push_back(128'h00000000_00000000_00000000_00000084);
    q_r.push_back({2'b00, 32'hFEED_0000});
    axi_read(32'h84);
    wait_tx_data();
    send_rx(32'd0, 32'hFEED_0000, 2'b00);
    repeat (6) @(posedge CLK); #1;

    chk("tx_queue_drained", q_tx.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    chk("r_queue_drained", q_r.size(), 0);
    chk("tag_error_pulses", seen_tagerr, exp_tagerr);
    chk("timeout_error_pulses", seen_to, exp_to);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
